riscv_issue_ctrl: RTL and testbench
===================================

Name: riscv_issue_ctrl

Overview:
- Single-issue scheduler between fetch and the functional units of the RV32 core.
- Latches one fetched instruction and decodes it with riscv_decoder.
- Tracks outstanding long-latency register writes in a 32-entry scoreboard, stalls on hazards and unit busy, and dispatches to exactly one unit per cycle (exec, lsu, branch, mul, div, csr).
- Serialises CSR/system/fault instructions and honours branch squash.

Parameters:
- ENABLE_MULDIV, 1, drives the decoder InEnableMuldiv input; 0 makes M-extension opcodes decode as invalid and go to the csr unit.

Ports:
- InClk  in  1  core clock
- InRstN  in  1  asynchronous active-low reset
- InFetchValid  in  1  fetch presents an instruction
- InFetchFault  in  1  fetch fault for the presented instruction
- InFetchOpcode  in  32  instruction word
- InFetchPc  in  32  instruction address
- OutFetchAccept  out  1  instruction taken this cycle
- InSquash  in  1  taken branch/redirect; drop the held instruction
- InLsuReady  in  1  lsu can accept this cycle
- InDivDone  in  1  divider finished, one-cycle pulse
- InCsrDone  in  1  csr unit finished, one-cycle pulse
- InWbValid  in  1  long-latency writeback occurring
- InWbRd  in  5  writeback destination
- OutExecValid, OutLsuValid, OutBranchValid, OutMulValid, OutDivValid, OutCsrValid  out  1 each  dispatch strobes, one-hot or all zero
- OutIssueOpcode  out  32  held opcode
- OutIssuePc  out  32  held pc
- OutIssueFault  out  1  held fetch fault
- OutIssueInvalid  out  1  decoder invalid flag for the held instruction
- OutBusy  out  1  hold valid, or any scoreboard bit set, or div busy, or CSR wait

Behaviour:
- Reset (async, InRstN=0):
  - HoldValid=0, scoreboard all 0, DivBusy=0, state IDLE.
  - All Out*Valid=0, OutFetchAccept=1, OutBusy=0.
  - OutIssueOpcode/Pc=0, OutIssueFault=0, OutIssueInvalid=0.
- Hold register (HoldValid, opcode, pc, fault):
  - Loaded when InFetchValid & OutFetchAccept.
  - Decode is combinational from the hold register.
  - Earliest dispatch is the cycle after acceptance, so latency is 1.
- Fire = HoldValid & ~Stall & ~InSquash & state==IDLE.
- OutFetchAccept = ~InSquash & state==IDLE & (~HoldValid | Fire).
- On InSquash: HoldValid cleared next edge and no fetch accepted that cycle. A squash in state WAIT_CSR does not abort the CSR operation.
- Field positions: rs1=[19:15], rs2=[24:20], rd=[11:7].
  - Hazard is checked on rs1 and rs2 regardless of format. This is conservative and intentional.
  - x0 is never pending.
- Stall when any of:
  - rs1, rs2 or rd has its scoreboard bit set (covers RAW and WAW).
  - lsu class and ~InLsuReady.
  - div class and DivBusy.
  - csr class and (any scoreboard bit set, or DivBusy).
- Unit selection priority: csr (includes invalid and fault) > lsu > branch > mul > div > exec. Exactly one Out*Valid is high on Fire.
- Scoreboard:
  - On Fire of lsu-load, mul, div or csr with OutRdValid and rd!=0, set sb[rd]. Stores set nothing.
  - InWbValid clears sb[InWbRd].
  - Same cycle, same register: set wins.
  - Hazard check reads the pre-update scoreboard, so an instruction waiting on a writeback issues one cycle after InWbValid.
  - Exec and branch results are forwarded and are not tracked.
- DivBusy: set on div Fire, cleared on InDivDone. If both occur in the same cycle, set wins.
- State machine:
  - IDLE -> WAIT_CSR on csr-class Fire.
  - WAIT_CSR -> IDLE on InCsrDone.
  - No dispatch and no fetch accept while in WAIT_CSR.
- InWbValid with rd=0, or for a clear bit: no effect.

Decomposition:
- Shared defines header (existing defs.v) gains the unit-select encodings and the rs1/rs2/rd field bit positions.
- Instruction masks come from the existing INST_* defines.
- One sub-module is natural: riscv_decoder, instantiated on the hold register. Its InValid is HoldValid, InFetchFault is the held fault, and InEnableMuldiv is ENABLE_MULDIV.
- Scoreboard and FSM stay inline.

Test Plan:
- Back-to-back ADDI x1,x0,1 then ADD x2,x1,x1 -> OutExecValid on two consecutive cycles, no stall, OutFetchAccept held at 1.
- LW x5,0(x0) then ADD x6,x5,x0 -> LW on OutLsuValid, sb[5]=1, ADD stalls. InWbValid/InWbRd=5 at cycle T -> ADD on OutExecValid at T+1, sb[5]=0.
- InLsuReady=0 for 3 cycles with SW held -> OutLsuValid low for 3 cycles, OutFetchAccept=0, fires in cycle 4.
- DIV x3 then DIV x4 (independent) -> second DIV waits for InDivDone, issuing the cycle after it. With ENABLE_MULDIV=0, DIV -> OutCsrValid, OutIssueInvalid=1.
- CSRRW x7 with sb[5] pending -> waits for InWbRd=5, then OutCsrValid. No accept until InCsrDone, then accept resumes the next cycle.
- InSquash while holding BEQ; InRstN low mid-WAIT_CSR -> no dispatch and hold dropped. After reset: state IDLE, scoreboard 0, OutBusy=0, OutFetchAccept=1.

Source files
------------

// File: rtl/riscv_issue_ctrl_pkg.sv
// Shared types and constants for the issue controller and its decoder.
package riscv_issue_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Register field positions within the instruction word
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_LSB  = 7;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // SYSTEM funct3==0 encodings, instruction bits [31:7]
  localparam logic [24:0] SYS_ECALL  = {12'h000, 13'h0000};
  localparam logic [24:0] SYS_EBREAK = {12'h001, 13'h0000};
  localparam logic [24:0] SYS_MRET   = {12'h302, 13'h0000};
  localparam logic [24:0] SYS_WFI    = {12'h105, 13'h0000};

  // Functional unit selected for a held instruction
  typedef enum logic [2:0] {
    UNIT_NONE   = 3'd0,
    UNIT_EXEC   = 3'd1,
    UNIT_LSU    = 3'd2,
    UNIT_BRANCH = 3'd3,
    UNIT_MUL    = 3'd4,
    UNIT_DIV    = 3'd5,
    UNIT_CSR    = 3'd6
  } unit_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_CSR = 1'b1
  } state_e;

  // Decoder result for the held instruction
  typedef struct packed {
    unit_e unit;
    logic  rd_valid;
    logic  is_load;
    logic  invalid;
  } dec_t;

  function automatic logic [REG_AW-1:0] field_rs1(input logic [XLEN-1:0] op);
    return op[RS1_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] field_rs2(input logic [XLEN-1:0] op);
    return op[RS2_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] field_rd(input logic [XLEN-1:0] op);
    return op[RD_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/riscv_issue_ctrl_decoder.sv
// RV32IM class decoder: picks the target unit and flags invalid encodings.
module riscv_issue_ctrl_decoder
  import riscv_issue_ctrl_pkg::*;
(
  input  logic            InValid,
  input  logic            InFetchFault,
  input  logic            InEnableMuldiv,
  input  logic [XLEN-1:0] InOpcode,
  output dec_t            OutDec
);

  logic [6:0]  opc_c;
  logic [2:0]  funct3_c;
  logic [6:0]  funct7_c;
  logic [24:0] sys_c;
  dec_t        dec_c;

  assign opc_c    = InOpcode[6:0];
  assign funct3_c = InOpcode[14:12];
  assign funct7_c = InOpcode[31:25];
  assign sys_c    = InOpcode[31:7];

  // Classify the opcode; faults and invalid encodings are routed to csr
  always_comb begin
    dec_c.unit     = UNIT_NONE;
    dec_c.rd_valid = 1'b0;
    dec_c.is_load  = 1'b0;
    dec_c.invalid  = 1'b0;
    case (opc_c)
      OPC_LUI, OPC_AUIPC: begin
        dec_c.unit     = UNIT_EXEC;
        dec_c.rd_valid = 1'b1;
      end
      OPC_JAL: begin
        dec_c.unit     = UNIT_BRANCH;
        dec_c.rd_valid = 1'b1;
      end
      OPC_JALR: begin
        if (funct3_c == 3'd0) begin
          dec_c.unit     = UNIT_BRANCH;
          dec_c.rd_valid = 1'b1;
        end else begin
          dec_c.invalid = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3_c == 3'd2 || funct3_c == 3'd3) dec_c.invalid = 1'b1;
        else                                      dec_c.unit    = UNIT_BRANCH;
      end
      OPC_LOAD: begin
        if (funct3_c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          dec_c.unit     = UNIT_LSU;
          dec_c.rd_valid = 1'b1;
          dec_c.is_load  = 1'b1;
        end else begin
          dec_c.invalid = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3_c <= 3'd2) dec_c.unit    = UNIT_LSU;
        else                  dec_c.invalid = 1'b1;
      end
      OPC_OP_IMM: begin
        if ((funct3_c == 3'd1 && funct7_c != 7'h00) ||
            (funct3_c == 3'd5 && funct7_c != 7'h00 && funct7_c != 7'h20)) begin
          dec_c.invalid = 1'b1;
        end else begin
          dec_c.unit     = UNIT_EXEC;
          dec_c.rd_valid = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7_c == 7'h00 ||
            (funct7_c == 7'h20 && (funct3_c == 3'd0 || funct3_c == 3'd5))) begin
          dec_c.unit     = UNIT_EXEC;
          dec_c.rd_valid = 1'b1;
        end else if (funct7_c == 7'h01 && InEnableMuldiv) begin
          dec_c.unit     = funct3_c[2] ? UNIT_DIV : UNIT_MUL;
          dec_c.rd_valid = 1'b1;
        end else begin
          dec_c.invalid = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // fences are serialised through the csr path
        if (funct3_c == 3'd0 || funct3_c == 3'd1) dec_c.unit    = UNIT_CSR;
        else                                      dec_c.invalid = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3_c == 3'd0) begin
          if (sys_c inside {SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_WFI}) dec_c.unit = UNIT_CSR;
          else                                                          dec_c.invalid = 1'b1;
        end else if (funct3_c == 3'd4) begin
          dec_c.invalid = 1'b1;
        end else begin
          dec_c.unit     = UNIT_CSR;
          dec_c.rd_valid = 1'b1;
        end
      end
      default: dec_c.invalid = 1'b1;
    endcase

    if (dec_c.invalid || InFetchFault) begin
      dec_c.unit     = UNIT_CSR;
      dec_c.rd_valid = 1'b0;
      dec_c.is_load  = 1'b0;
    end

    if (!InValid) begin
      dec_c.unit     = UNIT_NONE;
      dec_c.rd_valid = 1'b0;
      dec_c.is_load  = 1'b0;
      dec_c.invalid  = 1'b0;
    end
  end

  assign OutDec = dec_c;

endmodule

// File: rtl/riscv_issue_ctrl.sv
// Single-issue scheduler: hold register, scoreboard, hazard stall and unit dispatch.
module riscv_issue_ctrl
  import riscv_issue_ctrl_pkg::*;
#(
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic            InClk,
  input  logic            InRstN,
  input  logic            InFetchValid,
  input  logic            InFetchFault,
  input  logic [XLEN-1:0] InFetchOpcode,
  input  logic [XLEN-1:0] InFetchPc,
  output logic            OutFetchAccept,
  input  logic            InSquash,
  input  logic            InLsuReady,
  input  logic            InDivDone,
  input  logic            InCsrDone,
  input  logic            InWbValid,
  input  logic [REG_AW-1:0] InWbRd,
  output logic            OutExecValid,
  output logic            OutLsuValid,
  output logic            OutBranchValid,
  output logic            OutMulValid,
  output logic            OutDivValid,
  output logic            OutCsrValid,
  output logic [XLEN-1:0] OutIssueOpcode,
  output logic [XLEN-1:0] OutIssuePc,
  output logic            OutIssueFault,
  output logic            OutIssueInvalid,
  output logic            OutBusy
);

  logic                hold_valid_q, hold_valid_d;
  logic [XLEN-1:0]     hold_opcode_q, hold_opcode_d;
  logic [XLEN-1:0]     hold_pc_q, hold_pc_d;
  logic                hold_fault_q, hold_fault_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                div_busy_q, div_busy_d;
  state_e              state_q, state_d;

  dec_t              dec_c;
  logic [REG_AW-1:0] rs1_c, rs2_c, rd_c;
  logic              hazard_c, stall_c, fire_c, accept_c, sb_set_c;

  riscv_issue_ctrl_decoder u_riscv_decoder (
    .InValid        (hold_valid_q),
    .InFetchFault   (hold_fault_q),
    .InEnableMuldiv (ENABLE_MULDIV),
    .InOpcode       (hold_opcode_q),
    .OutDec         (dec_c)
  );

  assign rs1_c = field_rs1(hold_opcode_q);
  assign rs2_c = field_rs2(hold_opcode_q);
  assign rd_c  = field_rd(hold_opcode_q);

  // Hazards use the pre-update scoreboard; sb[0] is held at zero so x0 never stalls
  assign hazard_c = sb_q[rs1_c] | sb_q[rs2_c] | sb_q[rd_c];
  assign stall_c  = hazard_c
                  | ((dec_c.unit == UNIT_LSU) & ~InLsuReady)
                  | ((dec_c.unit == UNIT_DIV) & div_busy_q)
                  | ((dec_c.unit == UNIT_CSR) & ((|sb_q) | div_busy_q));
  assign fire_c   = hold_valid_q & ~stall_c & ~InSquash & (state_q == ST_IDLE);
  assign accept_c = ~InSquash & (state_q == ST_IDLE) & (~hold_valid_q | fire_c);

  // Long-latency writers are tracked; exec/branch results are forwarded
  assign sb_set_c = fire_c & dec_c.rd_valid & (rd_c != REG_AW'(0))
                  & (dec_c.is_load | (dec_c.unit == UNIT_MUL) |
                     (dec_c.unit == UNIT_DIV) | (dec_c.unit == UNIT_CSR));

  // Next-state for hold register, scoreboard, divider busy and serialisation FSM
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_opcode_d = hold_opcode_q;
    hold_pc_d     = hold_pc_q;
    hold_fault_d  = hold_fault_q;
    sb_d          = sb_q;
    div_busy_d    = div_busy_q;
    state_d       = state_q;

    if (InSquash) begin
      hold_valid_d = 1'b0;
    end else if (accept_c && InFetchValid) begin
      hold_valid_d  = 1'b1;
      hold_opcode_d = InFetchOpcode;
      hold_pc_d     = InFetchPc;
      hold_fault_d  = InFetchFault;
    end else if (fire_c) begin
      hold_valid_d = 1'b0;
    end

    // Clear before set so a same-cycle set on the same register wins
    if (InWbValid) sb_d[InWbRd] = 1'b0;
    if (sb_set_c)  sb_d[rd_c]   = 1'b1;
    sb_d[0] = 1'b0;

    if (InDivDone)                           div_busy_d = 1'b0;
    if (fire_c && dec_c.unit == UNIT_DIV)    div_busy_d = 1'b1;

    case (state_q)
      ST_IDLE:     if (fire_c && dec_c.unit == UNIT_CSR) state_d = ST_WAIT_CSR;
      ST_WAIT_CSR: if (InCsrDone)                        state_d = ST_IDLE;
      default:                                           state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      hold_valid_q  <= 1'b0;
      hold_opcode_q <= '0;
      hold_pc_q     <= '0;
      hold_fault_q  <= 1'b0;
      sb_q          <= '0;
      div_busy_q    <= 1'b0;
      state_q       <= ST_IDLE;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_opcode_q <= hold_opcode_d;
      hold_pc_q     <= hold_pc_d;
      hold_fault_q  <= hold_fault_d;
      sb_q          <= sb_d;
      div_busy_q    <= div_busy_d;
      state_q       <= state_d;
    end
  end

  assign OutFetchAccept  = accept_c;
  assign OutExecValid    = fire_c & (dec_c.unit == UNIT_EXEC);
  assign OutLsuValid     = fire_c & (dec_c.unit == UNIT_LSU);
  assign OutBranchValid  = fire_c & (dec_c.unit == UNIT_BRANCH);
  assign OutMulValid     = fire_c & (dec_c.unit == UNIT_MUL);
  assign OutDivValid     = fire_c & (dec_c.unit == UNIT_DIV);
  assign OutCsrValid     = fire_c & (dec_c.unit == UNIT_CSR);
  assign OutIssueOpcode  = hold_opcode_q;
  assign OutIssuePc      = hold_pc_q;
  assign OutIssueFault   = hold_fault_q;
  assign OutIssueInvalid = dec_c.invalid;
  assign OutBusy         = hold_valid_q | (|sb_q) | div_busy_q | (state_q == ST_WAIT_CSR);

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
// Randomised bench for riscv_issue_ctrl against a transaction-level issue model.
module tb_riscv_issue_ctrl;

  localparam int unsigned U_NONE = 0;
  localparam int unsigned U_EXEC = 1;
  localparam int unsigned U_LSU  = 2;
  localparam int unsigned U_BR   = 3;
  localparam int unsigned U_MUL  = 4;
  localparam int unsigned U_DIV  = 5;
  localparam int unsigned U_CSR  = 6;

  typedef struct {
    logic [31:0] op;
    logic        fault;
    int unsigned unit;
    bit          writes;
    bit          invalid;
  } instr_t;

  logic        InClk = 1'b0;
  logic        InRstN = 1'b0;
  logic        InFetchValid = 1'b0, InFetchFault = 1'b0;
  logic [31:0] InFetchOpcode = '0, InFetchPc = '0;
  logic        InSquash = 1'b0, InLsuReady = 1'b1, InDivDone = 1'b0, InCsrDone = 1'b0;
  logic        InWbValid = 1'b0;
  logic [4:0]  InWbRd = '0;

  logic        OutFetchAccept, OutExecValid, OutLsuValid, OutBranchValid;
  logic        OutMulValid, OutDivValid, OutCsrValid;
  logic [31:0] OutIssueOpcode, OutIssuePc;
  logic        OutIssueFault, OutIssueInvalid, OutBusy;

  logic        n_accept, n_exec, n_lsu, n_br, n_mul, n_div, n_csr;
  logic [31:0] n_opcode, n_pc;
  logic        n_fault, n_invalid, n_busy;

  riscv_issue_ctrl #(.ENABLE_MULDIV(1'b1)) u_dut (
    .InClk(InClk), .InRstN(InRstN), .InFetchValid(InFetchValid), .InFetchFault(InFetchFault),
    .InFetchOpcode(InFetchOpcode), .InFetchPc(InFetchPc), .OutFetchAccept(OutFetchAccept),
    .InSquash(InSquash), .InLsuReady(InLsuReady), .InDivDone(InDivDone), .InCsrDone(InCsrDone),
    .InWbValid(InWbValid), .InWbRd(InWbRd), .OutExecValid(OutExecValid), .OutLsuValid(OutLsuValid),
    .OutBranchValid(OutBranchValid), .OutMulValid(OutMulValid), .OutDivValid(OutDivValid),
    .OutCsrValid(OutCsrValid), .OutIssueOpcode(OutIssueOpcode), .OutIssuePc(OutIssuePc),
    .OutIssueFault(OutIssueFault), .OutIssueInvalid(OutIssueInvalid), .OutBusy(OutBusy)
  );

  riscv_issue_ctrl #(.ENABLE_MULDIV(1'b0)) u_dut_nomd (
    .InClk(InClk), .InRstN(InRstN), .InFetchValid(InFetchValid), .InFetchFault(InFetchFault),
    .InFetchOpcode(InFetchOpcode), .InFetchPc(InFetchPc), .OutFetchAccept(n_accept),
    .InSquash(InSquash), .InLsuReady(InLsuReady), .InDivDone(InDivDone), .InCsrDone(InCsrDone),
    .InWbValid(InWbValid), .InWbRd(InWbRd), .OutExecValid(n_exec), .OutLsuValid(n_lsu),
    .OutBranchValid(n_br), .OutMulValid(n_mul), .OutDivValid(n_div),
    .OutCsrValid(n_csr), .OutIssueOpcode(n_opcode), .OutIssuePc(n_pc),
    .OutIssueFault(n_fault), .OutIssueInvalid(n_invalid), .OutBusy(n_busy)
  );

  always #5 InClk = ~InClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending-write set, divider/csr occupancy, held instruction
  bit          pend [32];
  bit          div_busy, csr_wait, held;
  instr_t      cur, fin;
  logic [31:0] fin_pc;
  logic [31:0] last_op, last_pc;
  logic        last_fault;
  bit          nomd_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t gen_instr();
    instr_t      t;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int unsigned k;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    k   = $urandom_range(0, 10);
    t.fault = 1'b0; t.writes = 1'b0; t.invalid = 1'b0; t.unit = U_NONE; t.op = '0;
    case (k)
      0: begin t.op = {imm, rs1, 3'b000, rd, 7'h13}; t.unit = U_EXEC; end
      1: begin t.op = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; t.unit = U_EXEC; end
      2: begin t.op = {imm, rs1, 3'b010, rd, 7'h03}; t.unit = U_LSU; t.writes = (rd != 0); end
      3: begin t.op = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23}; t.unit = U_LSU; end
      4: begin t.op = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'h63}; t.unit = U_BR; end
      5: begin t.op = {imm, rs1, 3'b000, rd, 7'h6f}; t.unit = U_BR; end
      6: begin t.op = {7'h01, rs2, rs1, 3'b000, rd, 7'h33}; t.unit = U_MUL; t.writes = (rd != 0); end
      7: begin t.op = {7'h01, rs2, rs1, 3'b100, rd, 7'h33}; t.unit = U_DIV; t.writes = (rd != 0); end
      8: begin t.op = {imm, rs1, 3'b001, rd, 7'h73}; t.unit = U_CSR; t.writes = (rd != 0); end
      9: begin t.op = 32'hffff_ffff; t.unit = U_CSR; t.invalid = 1'b1; end
      default: begin t.op = {imm, rs1, 3'b000, rd, 7'h13}; t.fault = 1'b1; t.unit = U_CSR; end
    endcase
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    div_busy = 1'b0; csr_wait = 1'b0; held = 1'b0;
    cur.op = '0; cur.fault = 1'b0; cur.unit = U_NONE; cur.writes = 1'b0; cur.invalid = 1'b0;
    last_op = '0; last_pc = '0; last_fault = 1'b0;
  endtask

  task automatic drive_quiet();
    InFetchValid = 1'b0; InFetchFault = 1'b0; InSquash = 1'b0; InLsuReady = 1'b1;
    InDivDone = 1'b0; InCsrDone = 1'b0; InWbValid = 1'b0; InWbRd = '0;
  endtask

  task automatic present(input instr_t t, input logic [31:0] pc);
    fin = t; fin_pc = pc;
    InFetchValid = 1'b1; InFetchOpcode = t.op; InFetchFault = t.fault; InFetchPc = pc;
  endtask

  task automatic drive_random();
    int unsigned r;
    present(gen_instr(), $urandom & 32'hffff_fffc);
    InFetchValid = ($urandom_range(0, 9) < 7);
    InSquash     = ($urandom_range(0, 19) == 0);
    InLsuReady   = ($urandom_range(0, 3) != 0);
    InDivDone    = div_busy && ($urandom_range(0, 3) == 0);
    InCsrDone    = csr_wait && ($urandom_range(0, 2) == 0);
    r            = $urandom_range(0, 7);
    InWbRd       = 5'(r);
    InWbValid    = pend[r] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
  endtask

  // Compare this cycle's DUT outputs to the model, then advance the model one edge
  task automatic check_cycle();
    int unsigned u;
    bit          anyp, hz, blk, go, acc;
    logic [4:0]  r1, r2, rdf;
    logic [5:0]  exp_disp;
    u    = held ? cur.unit : U_NONE;
    r1   = cur.op[19:15];
    r2   = cur.op[24:20];
    rdf  = cur.op[11:7];
    anyp = 1'b0;
    for (int i = 0; i < 32; i++) anyp |= pend[i];
    hz   = held && (pend[r1] || pend[r2] || pend[rdf]);
    blk  = hz || (u == U_LSU && !InLsuReady) || (u == U_DIV && div_busy) ||
           (u == U_CSR && (anyp || div_busy));
    go   = held && !blk && !InSquash && !csr_wait;
    acc  = !InSquash && !csr_wait && (!held || go);
    case (u)
      U_EXEC:  exp_disp = 6'b000001;
      U_LSU:   exp_disp = 6'b000010;
      U_BR:    exp_disp = 6'b000100;
      U_MUL:   exp_disp = 6'b001000;
      U_DIV:   exp_disp = 6'b010000;
      U_CSR:   exp_disp = 6'b100000;
      default: exp_disp = 6'b000000;
    endcase
    if (!go) exp_disp = 6'b000000;

    chk("dispatch", 32'({OutCsrValid, OutDivValid, OutMulValid, OutBranchValid,
                         OutLsuValid, OutExecValid}), 32'(exp_disp));
    chk("accept",  32'(OutFetchAccept),  32'(acc));
    chk("busy",    32'(OutBusy),         32'(held || anyp || div_busy || csr_wait));
    chk("opcode",  OutIssueOpcode,       last_op);
    chk("pc",      OutIssuePc,           last_pc);
    chk("fault",   32'(OutIssueFault),   32'(last_fault));
    chk("invalid", 32'(OutIssueInvalid), 32'(held && cur.invalid));
    if (nomd_chk) begin
      chk("nomd_dispatch", 32'({n_csr, n_div, n_mul, n_br, n_lsu, n_exec}), 32'(6'b100000));
      chk("nomd_invalid",  32'(n_invalid), 32'(1'b1));
    end

    if (InWbValid) pend[InWbRd] = 1'b0;
    if (go && cur.writes) pend[rdf] = 1'b1;
    if (InDivDone) div_busy = 1'b0;
    if (go && u == U_DIV) div_busy = 1'b1;
    if (go && u == U_CSR) csr_wait = 1'b1;
    else if (csr_wait && InCsrDone) csr_wait = 1'b0;
    if (InSquash) begin
      held = 1'b0;
    end else if (acc && InFetchValid) begin
      held = 1'b1; cur = fin;
      last_op = fin.op; last_pc = fin_pc; last_fault = fin.fault;
    end else if (go) begin
      held = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge InClk);
    check_cycle();
    @(posedge InClk);
    #1;
  endtask

  task automatic rst_checks();
    chk("rst_dispatch", 32'({OutCsrValid, OutDivValid, OutMulValid, OutBranchValid,
                             OutLsuValid, OutExecValid}), 32'(0));
    chk("rst_accept",  32'(OutFetchAccept), 32'(1));
    chk("rst_busy",    32'(OutBusy),        32'(0));
    chk("rst_opcode",  OutIssueOpcode,      32'(0));
    chk("rst_pc",      OutIssuePc,          32'(0));
    chk("rst_fault",   32'(OutIssueFault),  32'(0));
    chk("rst_invalid", 32'(OutIssueInvalid), 32'(0));
    chk("rst_nomd_busy", 32'(n_busy), 32'(0));
  endtask

  task automatic apply_reset();
    InRstN = 1'b0;
    drive_quiet();
    #1;
    rst_checks();
    model_reset();
    @(posedge InClk);
    #1;
    rst_checks();
    InRstN = 1'b1;
  endtask

  instr_t t_div, t_csr;

  initial begin
    model_reset();
    apply_reset();

    for (int c = 0; c < 3000; c++) begin
      drive_random();
      cycle();
    end

    // M-extension disabled: DIV must be invalid and go to csr
    apply_reset();
    t_div.op = {7'h01, 5'd2, 5'd1, 3'b100, 5'd3, 7'h33};
    t_div.fault = 1'b0; t_div.unit = U_DIV; t_div.writes = 1'b1; t_div.invalid = 1'b0;
    present(t_div, 32'h0000_0100);
    cycle();
    InFetchValid = 1'b0;
    nomd_chk = 1'b1;
    cycle();
    nomd_chk = 1'b0;

    // Reset asserted while a CSR operation is outstanding
    apply_reset();
    t_csr.op = {12'h300, 5'd1, 3'b001, 5'd7, 7'h73};
    t_csr.fault = 1'b0; t_csr.unit = U_CSR; t_csr.writes = 1'b1; t_csr.invalid = 1'b0;
    present(t_csr, 32'h0000_0200);
    cycle();
    InFetchValid = 1'b0;
    cycle();
    cycle();
    chk("csr_wait_busy", 32'(OutBusy), 32'(1));
    #2;
    apply_reset();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
